// File: rtl/seg_ascii_pkg.sv
// Shared constants, FSM state type and character formatting for the
// binary-to-ASCII digit converter feeding the 6-digit ASCII display driver.
package seg_ascii_pkg;

  localparam logic [7:0] CH_BLANK   = 8'd0;
  localparam logic [7:0] CH_ZERO    = 8'd48;
  localparam logic [7:0] CH_DASH    = 8'd45;
  localparam int         NUM_DIGITS = 6;
  localparam int         BCD_W      = 4 * NUM_DIGITS;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    FORMAT
  } state_t;

  // Maps packed BCD to display characters; digit 0 is never blanked so a
  // zero value still shows a single '0'.
  function automatic logic [NUM_DIGITS-1:0][7:0] format_chars(
    input logic [BCD_W-1:0] bcd,
    input logic             ovf,
    input logic             blank_lz
  );
    logic [NUM_DIGITS-1:0][7:0] chars;
    logic                       leading;
    logic [3:0]                 nibble;
    chars   = '0;
    leading = blank_lz;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      nibble = bcd[4*i +: 4];
      if (ovf) begin
        chars[i] = CH_DASH;
      end else if (leading && (i != 0) && (nibble == 4'd0)) begin
        chars[i] = CH_BLANK;
      end else begin
        chars[i] = CH_ZERO + {4'd0, nibble};
        leading  = 1'b0;
      end
    end
    return chars;
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: adds 3 to a BCD nibble of 5 or more so the
// following left shift carries correctly into the next decimal digit.
module bcd_add3 (
  input  logic [3:0] nibble,
  output logic [3:0] adjusted
);

  assign adjusted = (nibble >= 4'd5) ? nibble + 4'd3 : nibble;

endmodule

// File: rtl/bin2ascii_digits.sv
// Sequential double-dabble converter: one input bit per clock, then one
// FORMAT cycle that registers all six ASCII characters at once.
module bin2ascii_digits
  import seg_ascii_pkg::*;
#(
  parameter int WIDTH    = 20,
  parameter bit BLANK_LZ = 1'b1,
  parameter int MAX_VAL  = 999999
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] value,
  output logic             busy,
  output logic             done,
  output logic [7:0]       char0,
  output logic [7:0]       char1,
  output logic [7:0]       char2,
  output logic [7:0]       char3,
  output logic [7:0]       char4,
  output logic [7:0]       char5
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t                     state;
  state_t                     state_next;
  logic                       load;
  logic                       shift_en;
  logic                       format_en;
  logic [WIDTH-1:0]           bin_reg;
  logic [BCD_W-1:0]           bcd_reg;
  logic [BCD_W-1:0]           bcd_adj;
  logic [CNT_W-1:0]           bit_cnt;
  logic                       ovf;
  logic [NUM_DIGITS-1:0][7:0] char_q;

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_add3
    bcd_add3 u_add3 (
      .nibble   (bcd_reg[4*i +: 4]),
      .adjusted (bcd_adj[4*i +: 4])
    );
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // The done cycle is skipped for acceptance so a held start restarts one
  // cycle after done, giving the display a full cycle of stable characters.
  // NOTE: every always_comb output gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    shift_en   = 1'b0;
    format_en  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start && !done) begin
          load       = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        shift_en = 1'b1;
        if (bit_cnt == CNT_W'(WIDTH - 1)) state_next = FORMAT;
      end
      FORMAT: begin
        format_en  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_reg <= '0;
      bcd_reg <= '0;
      bit_cnt <= '0;
      ovf     <= 1'b0;
    end else if (load) begin
      bin_reg <= value;
      bcd_reg <= '0;
      bit_cnt <= '0;
      ovf     <= (value > WIDTH'(MAX_VAL));
    end else if (shift_en) begin
      bin_reg <= {bin_reg[WIDTH-2:0], 1'b0};
      bcd_reg <= {bcd_adj[BCD_W-2:0], bin_reg[WIDTH-1]};
      bit_cnt <= bit_cnt + 1'b1;
      // A carry out of the top digit can only mean the value is too large.
      ovf     <= ovf | bcd_adj[BCD_W-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done   <= 1'b0;
      char_q <= '0;
    end else begin
      done <= format_en;
      if (format_en) char_q <= format_chars(bcd_reg, ovf, BLANK_LZ);
    end
  end

  assign busy  = (state != IDLE);
  assign char0 = char_q[0];
  assign char1 = char_q[1];
  assign char2 = char_q[2];
  assign char3 = char_q[3];
  assign char4 = char_q[4];
  assign char5 = char_q[5];

endmodule

// File: tb/tb_bin2ascii_digits.sv
// Self-checking bench: two converters (leading-zero blanking on and off)
// driven in parallel, checked against directed vectors and a decimal model.
module tb_bin2ascii_digits;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [19:0] value;
  logic        b_busy, b_done, n_busy, n_done;
  logic [7:0]  b_c0, b_c1, b_c2, b_c3, b_c4, b_c5;
  logic [7:0]  n_c0, n_c1, n_c2, n_c3, n_c4, n_c5;
  logic [47:0] chars_b, chars_n;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bin2ascii_digits #(.WIDTH(20), .BLANK_LZ(1'b1), .MAX_VAL(999999)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .value(value),
    .busy(b_busy), .done(b_done),
    .char0(b_c0), .char1(b_c1), .char2(b_c2),
    .char3(b_c3), .char4(b_c4), .char5(b_c5)
  );

  bin2ascii_digits #(.WIDTH(20), .BLANK_LZ(1'b0), .MAX_VAL(999999)) dut_nb (
    .clk(clk), .rst_n(rst_n), .start(start), .value(value),
    .busy(n_busy), .done(n_done),
    .char0(n_c0), .char1(n_c1), .char2(n_c2),
    .char3(n_c3), .char4(n_c4), .char5(n_c5)
  );

  assign chars_b = {b_c5, b_c4, b_c3, b_c2, b_c1, b_c0};
  assign chars_n = {n_c5, n_c4, n_c3, n_c2, n_c1, n_c0};

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Decimal reference: digits by division, packed {char5..char0}.
  function automatic logic [47:0] model(input int unsigned v, input bit blank);
    logic [47:0] r;
    int unsigned d;
    bit leading;
    r = '0;
    leading = blank;
    for (int i = 5; i >= 0; i--) begin
      d = (v / (10 ** i)) % 10;
      if (v > 999999)                       r[8*i +: 8] = 8'd45;
      else if (leading && i > 0 && d == 0)  r[8*i +: 8] = 8'd0;
      else begin
        r[8*i +: 8] = 8'(48 + d);
        leading = 1'b0;
      end
    end
    return r;
  endfunction

  // Runs one conversion; lat = cycles from accept edge to done, bcnt = busy cycles.
  task automatic convert(input logic [19:0] v, output int lat, output int bcnt);
    int k;
    @(posedge clk);
    @(negedge clk);
    start = 1'b1;
    value = v;
    @(posedge clk);
    #1;
    start = 1'b0;
    k = 1;
    bcnt = 0;
    while (k < 40 && !b_done) begin
      if (b_busy) bcnt++;
      @(posedge clk);
      #1;
      k++;
    end
    lat = k;
  endtask

  typedef struct {
    logic [19:0] value;
    logic [47:0] exp_b;
    logic [47:0] exp_n;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int lat, bcnt, t, t1, t2, ndone;

    vecs[0] = '{20'd0,       {8'd0,8'd0,8'd0,8'd0,8'd0,8'd48},     {6{8'd48}}};
    vecs[1] = '{20'd123456,  {8'd49,8'd50,8'd51,8'd52,8'd53,8'd54}, {8'd49,8'd50,8'd51,8'd52,8'd53,8'd54}};
    vecs[2] = '{20'd999999,  {6{8'd57}},                            {6{8'd57}}};
    vecs[3] = '{20'd1000000, {6{8'd45}},                            {6{8'd45}}};
    vecs[4] = '{20'd42,      {8'd0,8'd0,8'd0,8'd0,8'd52,8'd50},     {8'd48,8'd48,8'd48,8'd48,8'd52,8'd50}};
    vecs[5] = '{20'd100005,  {8'd49,8'd48,8'd48,8'd48,8'd48,8'd53}, {8'd49,8'd48,8'd48,8'd48,8'd48,8'd53}};
    vecs[6] = '{20'd1048575, {6{8'd45}},                            {6{8'd45}}};
    vecs[7] = '{20'd10,      {8'd0,8'd0,8'd0,8'd0,8'd49,8'd48},     {8'd48,8'd48,8'd48,8'd48,8'd49,8'd48}};

    rst_n = 1'b0;
    start = 1'b0;
    value = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 64'(b_busy), 64'd0);
    check("reset_done", 64'(b_done), 64'd0);
    check("reset_chars", 64'(chars_b), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("idle_busy", 64'(b_busy), 64'd0);

    for (int i = 0; i < 8; i++) begin
      convert(vecs[i].value, lat, bcnt);
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'd22);
      check($sformatf("vec%0d_busy_cycles", i), 64'(bcnt), 64'd21);
      check($sformatf("vec%0d_busy_at_done", i), 64'(b_busy), 64'd0);
      check($sformatf("vec%0d_chars_blank", i), 64'(chars_b), 64'(vecs[i].exp_b));
      check($sformatf("vec%0d_chars_noblank", i), 64'(chars_n), 64'(vecs[i].exp_n));
    end

    // Start during busy is ignored; value change after accept has no effect.
    @(posedge clk);
    @(negedge clk);
    start = 1'b1;
    value = 20'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    ndone = 0;
    lat = 0;
    for (int k = 1; k <= 45; k++) begin
      if (k == 5) begin start = 1'b1; value = 20'd9; end
      if (k == 6) start = 1'b0;
      if (b_done) begin
        ndone++;
        if (lat == 0) lat = k;
      end
      @(posedge clk);
      #1;
    end
    check("ignore_done_count", 64'(ndone), 64'd1);
    check("ignore_latency", 64'(lat), 64'd22);
    check("ignore_char0", 64'(b_c0), 64'd55);
    convert(20'd9, lat, bcnt);
    check("after_ignore_char0", 64'(b_c0), 64'd57);

    // Start held high: next accept is the cycle after done.
    @(posedge clk);
    @(negedge clk);
    start = 1'b1;
    value = 20'd5;
    t1 = -1;
    t2 = -1;
    for (int k = 1; k <= 80; k++) begin
      @(posedge clk);
      #1;
      if (b_done) begin
        if (t1 < 0) begin
          t1 = k;
          check("held_first_chars", 64'(chars_b), 64'(model(5, 1'b1)));
          value = 20'd6;
        end else begin
          t2 = k;
          check("held_second_chars", 64'(chars_b), 64'(model(6, 1'b1)));
          start = 1'b0;
          break;
        end
      end
    end
    start = 1'b0;
    check("held_first_latency", 64'(t1), 64'd22);
    check("held_done_spacing", 64'(t2 - t1), 64'd23);

    // Reset in the middle of SHIFT.
    @(posedge clk);
    @(negedge clk);
    start = 1'b1;
    value = 20'd123456;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int k = 1; k < 10; k++) begin
      @(posedge clk);
      #1;
    end
    check("midrst_busy_before", 64'(b_busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 64'(b_busy), 64'd0);
    check("midrst_done", 64'(b_done), 64'd0);
    check("midrst_chars", 64'(chars_b), 64'd0);
    check("midrst_chars_nb", 64'(chars_n), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk);
      #1;
      if (b_done) ndone++;
    end
    check("midrst_no_done", 64'(ndone), 64'd0);
    convert(20'd42, lat, bcnt);
    check("midrst_next_latency", 64'(lat), 64'd22);
    check("midrst_next_chars", 64'(chars_b), 64'(model(42, 1'b1)));

    // Randomized values against the decimal model.
    for (int i = 0; i < 40; i++) begin
      int unsigned v;
      case ($urandom_range(0, 3))
        0:       v = $urandom_range(0, 999);
        1:       v = $urandom_range(1000000, 1048575);
        default: v = $urandom_range(0, 999999);
      endcase
      convert(20'(v), lat, bcnt);
      check($sformatf("rand%0d_latency v=%0d", i, v), 64'(lat), 64'd22);
      check($sformatf("rand%0d_blank v=%0d", i, v), 64'(chars_b), 64'(model(v, 1'b1)));
      check($sformatf("rand%0d_noblank v=%0d", i, v), 64'(chars_n), 64'(model(v, 1'b0)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
